// File: rtl/stego_pkg.sv
// Shared types and constants for the stego core arbiter.
package stego_pkg;

  localparam int DATA_W_DEF = 8;

  // Value driven on core_owner: the core picks its key/data source from it
  localparam logic OWNER_WB  = 1'b0;
  localparam logic OWNER_PIN = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    WAIT,
    RESP
  } state_t;

endpackage

// File: rtl/stego_sync.sv
// Multi-flop synchroniser for a single asynchronous level, resets to 0.
module stego_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  // Shift the async level through STAGES flops
  // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[STAGES-2:0], d};
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/stego_core_arbiter.sv
// Arbitrates the Wishbone and pin requesters onto a single LSB-embedding core,
// launches the core, waits for completion or timeout, and returns the result.
module stego_core_arbiter
  import stego_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int TIMEOUT     = 255,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk_wb,
  input  logic              rst_wb_n,
  input  logic              wb_cyc,
  input  logic              wb_stb,
  input  logic              wb_we,
  input  logic [DATA_W-1:0] wb_cover,
  output logic              wb_ack,
  output logic [DATA_W-1:0] wb_out,
  input  logic              pin_req,
  input  logic [DATA_W-1:0] pin_cover,
  output logic              pin_done,
  output logic [DATA_W-1:0] pin_out,
  input  logic              sel,
  output logic              core_start,
  output logic [DATA_W-1:0] core_cover,
  output logic              core_owner,
  output logic              core_abort,
  input  logic              core_done,
  input  logic [DATA_W-1:0] core_result,
  output logic              err_timeout,
  input  logic              err_clr
);

  localparam int              CNT_W   = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  state_t            state, state_nxt;
  logic              pin_req_s;
  logic              pin_armed;
  logic              last_owner;
  logic              wb_rd_ack;
  logic [DATA_W-1:0] wb_rd_data;
  logic [DATA_W-1:0] wb_last;
  logic [DATA_W-1:0] result_q;
  logic [CNT_W-1:0]  to_cnt;

  logic              wb_rd, wb_req, pin_ok, grant_owner, wb_resp;
  logic [DATA_W-1:0] result_nxt;

  stego_sync #(.STAGES(SYNC_STAGES)) u_pin_sync (
    .clk   (clk_wb),
    .rst_n (rst_wb_n),
    .d     (pin_req),
    .q     (pin_req_s)
  );

  // A read is only served from IDLE and takes precedence over a write that cycle
  assign wb_rd  = (state == IDLE) & wb_cyc & wb_stb & ~wb_we & ~wb_ack;
  assign wb_req = wb_cyc & wb_stb & wb_we & ~wb_ack;
  assign pin_ok = pin_req_s & pin_armed & ~sel;

  // On a tie the requester that did not go last wins
  assign grant_owner = (wb_req & pin_ok) ? ~last_owner :
                       (pin_ok ? OWNER_PIN : OWNER_WB);

  // A timeout reports a zero result; a late done on the last cycle still counts
  assign result_nxt = core_done ? core_result : '0;

  // Next state plus the single-cycle core strobes (abort reacts to core_done in the same cycle)
  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt  = state;
    core_start = 1'b0;
    core_abort = 1'b0;
    case (state)
      IDLE:  if (!wb_rd && (wb_req || pin_ok)) state_nxt = GRANT;
      GRANT: begin
        core_start = 1'b1;
        state_nxt  = WAIT;
      end
      WAIT: begin
        if (core_done) begin
          state_nxt = RESP;
        end else if (to_cnt == CNT_MAX) begin
          core_abort = 1'b1;
          state_nxt  = RESP;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk_wb or negedge rst_wb_n) begin
    if (!rst_wb_n) state <= IDLE;
    else           state <= state_nxt;
  end

  // Grant capture, timeout counting and result capture
  always_ff @(posedge clk_wb or negedge rst_wb_n) begin
    if (!rst_wb_n) begin
      core_cover <= '0;
      core_owner <= OWNER_WB;
      to_cnt     <= '0;
      result_q   <= '0;
      pin_out    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (state_nxt == GRANT) begin
            core_owner <= grant_owner;
            core_cover <= (grant_owner == OWNER_PIN) ? pin_cover : wb_cover;
          end
        end
        GRANT: to_cnt <= '0;
        WAIT: begin
          if (state_nxt == RESP) begin
            result_q <= result_nxt;
            if (core_owner == OWNER_PIN) pin_out <= result_nxt;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Read path, round-robin history, pin re-arm and the sticky timeout flag
  always_ff @(posedge clk_wb or negedge rst_wb_n) begin
    if (!rst_wb_n) begin
      wb_rd_ack   <= 1'b0;
      wb_rd_data  <= '0;
      wb_last     <= '0;
      last_owner  <= OWNER_PIN;
      pin_armed   <= 1'b1;
      err_timeout <= 1'b0;
    end else begin
      wb_rd_ack <= wb_rd;
      if (wb_rd) wb_rd_data <= wb_last;
      if (state == RESP) begin
        last_owner <= core_owner;
        if (core_owner == OWNER_WB) wb_last <= result_q;
      end
      // A held pin request is served once; it must be seen low before it counts again
      if (state == RESP && core_owner == OWNER_PIN) pin_armed <= 1'b0;
      else if (!pin_req_s)                          pin_armed <= 1'b1;
      if (core_abort)   err_timeout <= 1'b1;
      else if (err_clr) err_timeout <= 1'b0;
    end
  end

  assign wb_resp  = (state == RESP) & (core_owner == OWNER_WB);
  assign wb_ack   = wb_rd_ack | wb_resp;
  assign wb_out   = wb_resp ? result_q : (wb_rd_ack ? wb_rd_data : '0);
  assign pin_done = (state == RESP) & (core_owner == OWNER_PIN);

endmodule

// File: tb/tb_stego_core_arbiter.sv
// Self-checking bench for stego_core_arbiter: directed vector table, hand-written
// corner sequences and randomized transactions against a transaction-level model.
module tb_stego_core_arbiter;

  localparam int TO   = 15;
  localparam int SYNC = 2;

  logic       clk_wb = 1'b0;
  logic       rst_wb_n = 1'b0;
  logic       wb_cyc = 0, wb_stb = 0, wb_we = 0;
  logic [7:0] wb_cover = '0;
  logic       wb_ack;
  logic [7:0] wb_out;
  logic       pin_req = 0;
  logic [7:0] pin_cover = '0;
  logic       pin_done;
  logic [7:0] pin_out;
  logic       sel = 0;
  logic       core_start;
  logic [7:0] core_cover;
  logic       core_owner;
  logic       core_abort;
  logic       core_done = 0;
  logic [7:0] core_result = '0;
  logic       err_timeout;
  logic       err_clr = 0;

  int n_checks = 0;
  int n_pass   = 0;

  stego_core_arbiter #(.DATA_W(8), .TIMEOUT(TO), .SYNC_STAGES(SYNC)) dut (
    .clk_wb(clk_wb), .rst_wb_n(rst_wb_n),
    .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_cover(wb_cover),
    .wb_ack(wb_ack), .wb_out(wb_out),
    .pin_req(pin_req), .pin_cover(pin_cover), .pin_done(pin_done), .pin_out(pin_out),
    .sel(sel), .core_start(core_start), .core_cover(core_cover), .core_owner(core_owner),
    .core_abort(core_abort), .core_done(core_done), .core_result(core_result),
    .err_timeout(err_timeout), .err_clr(err_clr)
  );

  always #5 clk_wb = ~clk_wb;

  typedef struct {
    bit         do_wb;
    bit         do_pin;
    logic [7:0] wc;
    logic [7:0] pc;
    int         k0;
    int         k1;
    logic [7:0] r0;
    logic [7:0] r1;
    logic       exp_own0;
    logic [7:0] exp_cov0;
    logic [7:0] exp_cov1;
    logic [7:0] exp_wout;
    logic [7:0] exp_pout;
    int         exp_ab;
    logic       exp_err;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk_wb);
    #1;
  endtask

  // Drives the requested masters and plays the core: the i-th launch completes
  // k_i cycles after core_start (k > TO+1 means the core never answers).
  task automatic run_txn(input bit do_wb, input bit do_pin, input bit hold_pin,
                         input logic [7:0] wcov, input logic [7:0] pcov,
                         input int k0, input int k1, input logic [7:0] r0, input logic [7:0] r1,
                         output int n_st, output logic own0, output logic own1,
                         output logic [7:0] cov0, output logic [7:0] cov1,
                         output logic [7:0] wout, output logic [7:0] pout, output int n_ab);
    bit         wb_p, pin_p, busy, saw_ack, saw_pd;
    int         since, cur_k, exp_lat;
    logic [7:0] cur_r;
    n_st = 0; own0 = 0; own1 = 0; cov0 = 0; cov1 = 0; wout = 0; pout = 0; n_ab = 0;
    busy = 0; since = 0; cur_k = 0; cur_r = 0;
    if (do_pin) begin
      pin_cover = pcov;
      pin_req   = 1'b1;
      repeat (SYNC) step();
    end
    if (do_wb) begin
      wb_cover = wcov; wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1;
    end
    wb_p = do_wb; pin_p = do_pin;
    for (int cyc = 0; cyc < 200 && (wb_p || pin_p); cyc++) begin
      core_done   = busy && (since == cur_k);
      core_result = cur_r;
      if (core_done) busy = 0;
      saw_ack = 0; saw_pd = 0;
      @(negedge clk_wb);
      if (core_start) begin
        if (n_st == 0) begin
          check("start_latency", cyc, 1);
          own0 = core_owner; cov0 = core_cover; cur_k = k0; cur_r = r0;
        end else begin
          own1 = core_owner; cov1 = core_cover; cur_k = k1; cur_r = r1;
        end
        n_st++; busy = 1; since = 0;
      end
      if (core_abort) begin
        n_ab++; busy = 0;
        check("abort_cycle", since, TO + 1);
      end
      exp_lat = ((cur_k < TO + 1) ? cur_k : TO + 1) + 1;
      if (wb_ack && wb_p) begin
        wout = wb_out; saw_ack = 1;
        check("wb_resp_latency", since, exp_lat);
      end
      if (pin_done && pin_p) begin
        pout = pin_out; saw_pd = 1;
        check("pin_resp_latency", since, exp_lat);
      end
      step();
      since++;
      if (saw_ack) begin
        wb_cyc = 0; wb_stb = 0; wb_we = 0; wb_p = 0;
      end
      if (saw_pd) begin
        if (!hold_pin) pin_req = 1'b0;
        pin_p = 0;
      end
    end
    if (wb_p || pin_p) check("txn_budget", {30'd0, wb_p, pin_p}, 32'd0);
    core_done = 0;
    wb_cyc = 0; wb_stb = 0; wb_we = 0;
    if (!hold_pin) pin_req = 1'b0;
    repeat (SYNC + 2) step();
  endtask

  task automatic apply_vec(input vec_t v, input bit hold_pin, input string tag);
    int         n_st, n_ab;
    logic       own0, own1, exp_own1;
    logic [7:0] cov0, cov1, wout, pout;
    run_txn(v.do_wb, v.do_pin, hold_pin, v.wc, v.pc, v.k0, v.k1, v.r0, v.r1,
            n_st, own0, own1, cov0, cov1, wout, pout, n_ab);
    exp_own1 = ~v.exp_own0;
    check({tag, ".starts"}, n_st, int'(v.do_wb) + int'(v.do_pin));
    check({tag, ".owner0"}, own0, v.exp_own0);
    check({tag, ".cover0"}, cov0, v.exp_cov0);
    if (v.do_wb && v.do_pin) begin
      check({tag, ".owner1"}, own1, exp_own1);
      check({tag, ".cover1"}, cov1, v.exp_cov1);
    end
    if (v.do_wb)  check({tag, ".wb_out"}, wout, v.exp_wout);
    if (v.do_pin) check({tag, ".pin_out"}, pout, v.exp_pout);
    check({tag, ".aborts"}, n_ab, v.exp_ab);
    @(negedge clk_wb);
    check({tag, ".err_timeout"}, err_timeout, v.exp_err);
    step();
  endtask

  // Wishbone read: ack one cycle later with the last WB result, no core use,
  // and no back-to-back ack even while the strobe stays up.
  task automatic rd_txn(input logic [7:0] exp, input string tag);
    wb_cyc = 1; wb_stb = 1; wb_we = 0;
    @(negedge clk_wb);
    check({tag, ".ack_not_early"}, wb_ack, 1'b0);
    step();
    @(negedge clk_wb);
    check({tag, ".ack"}, wb_ack, 1'b1);
    check({tag, ".data"}, wb_out, exp);
    check({tag, ".no_core_start"}, core_start, 1'b0);
    step();
    @(negedge clk_wb);
    check({tag, ".ack_single"}, wb_ack, 1'b0);
    step();
    wb_cyc = 0; wb_stb = 0;
    repeat (2) step();
  endtask

  function automatic logic [29:0] all_outs();
    return {wb_ack, wb_out, pin_done, pin_out, core_start, core_cover,
            core_owner, core_abort, err_timeout};
  endfunction

  vec_t       tbl[5];
  vec_t       v;
  int         n, kind;
  bit         found;
  logic       m_last, m_err, f, s, wb_first;
  logic [7:0] m_wb_last, res0, res1;

  initial begin
    tbl[0] = '{1, 1, 8'h11, 8'h22, 2, 4,  8'h33, 8'h44, 1'b0, 8'h11, 8'h22, 8'h33, 8'h44, 0, 1'b0};
    tbl[1] = '{0, 1, 8'h00, 8'h99, 5, 0,  8'h9A, 8'h00, 1'b1, 8'h99, 8'h00, 8'h00, 8'h9A, 0, 1'b0};
    tbl[2] = '{1, 0, 8'hC3, 8'h00, 17, 0, 8'hDE, 8'h00, 1'b0, 8'hC3, 8'h00, 8'h00, 8'h00, 1, 1'b1};
    tbl[3] = '{1, 1, 8'h55, 8'h66, 1, 16, 8'h77, 8'h88, 1'b1, 8'h66, 8'h55, 8'h88, 8'h77, 0, 1'b1};
    tbl[4] = '{1, 0, 8'hA5, 8'h00, 3, 0,  8'hA4, 8'h00, 1'b0, 8'hA5, 8'h00, 8'hA4, 8'h00, 0, 1'b1};

    // Reset state
    @(negedge clk_wb);
    check("reset_outputs", all_outs(), 30'd0);
    step();
    rst_wb_n = 1'b1;
    step();
    @(negedge clk_wb);
    check("post_reset_outputs", all_outs(), 30'd0);
    step();

    // Directed vectors: tie order after reset, single requesters, timeout, done-on-last-cycle
    for (int i = 0; i < 5; i++) apply_vec(tbl[i], 1'b0, $sformatf("vec%0d", i));

    // Sticky timeout flag and its clear
    @(negedge clk_wb);
    check("err_sticky", err_timeout, 1'b1);
    step();
    err_clr = 1; step(); err_clr = 0;
    @(negedge clk_wb);
    check("err_cleared", err_timeout, 1'b0);
    step();

    // Read returns the last WB result
    rd_txn(8'hA4, "read_a4");

    // Pin held after pin_done is not served twice until it toggles
    v = '{0, 1, 8'h00, 8'h0F, 2, 0, 8'hF0, 8'h00, 1'b1, 8'h0F, 8'h00, 8'h00, 8'hF0, 0, 1'b0};
    apply_vec(v, 1'b1, "pin_hold");
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_wb); if (core_start) n++; step();
    end
    check("pin_hold_no_regrant", n, 0);
    pin_req = 0;
    repeat (SYNC + 2) step();
    v = '{0, 1, 8'h00, 8'h1E, 3, 0, 8'hE1, 8'h00, 1'b1, 8'h1E, 8'h00, 8'h00, 8'hE1, 0, 1'b0};
    apply_vec(v, 1'b0, "pin_retoggle");

    // Wishbone-only mode stalls the pin path; dropping sel releases it
    sel = 1; pin_cover = 8'h5B; pin_req = 1;
    n = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk_wb); if (core_start) n++; step();
    end
    check("sel_stall_starts", n, 0);
    sel = 0;
    found = 0;
    for (int i = 0; i < SYNC + 2 && !found; i++) begin
      @(negedge clk_wb);
      if (core_start) begin
        found = 1;
        check("sel_release_owner", core_owner, 1'b1);
        check("sel_release_cover", core_cover, 8'h5B);
      end
      step();
    end
    check("sel_release_granted", found, 1'b1);
    core_done = 1; core_result = 8'h5A;
    @(negedge clk_wb);
    check("sel_no_abort", core_abort, 1'b0);
    step();
    core_done = 0;
    @(negedge clk_wb);
    check("sel_pin_done", pin_done, 1'b1);
    check("sel_pin_out", pin_out, 8'h5A);
    step();
    pin_req = 0;
    repeat (SYNC + 2) step();

    // Asynchronous reset in WAIT clears every output at once
    wb_cover = 8'h77; wb_cyc = 1; wb_stb = 1; wb_we = 1;
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk_wb); if (core_start) found = 1; step();
    end
    check("rst_test_started", found, 1'b1);
    repeat (3) step();
    #2 rst_wb_n = 0;
    #1;
    check("async_reset_outputs", all_outs(), 30'd0);
    wb_cyc = 0; wb_stb = 0; wb_we = 0;
    step(); step();
    rst_wb_n = 1;
    step();
    v = '{1, 0, 8'h3C, 8'h00, 2, 0, 8'h3D, 8'h00, 1'b0, 8'h3C, 8'h00, 8'h3D, 8'h00, 0, 1'b0};
    apply_vec(v, 1'b0, "post_reset_write");

    // Randomized transactions against a transaction-level model
    m_last = 1'b0; m_wb_last = 8'h3D; m_err = 1'b0;
    for (int t = 0; t < 30; t++) begin
      kind = $urandom_range(0, 3);
      if (kind == 3) begin
        rd_txn(m_wb_last, $sformatf("rnd%0d_read", t));
      end else begin
        v.do_wb  = (kind != 1);
        v.do_pin = (kind != 0);
        v.wc = 8'($urandom); v.pc = 8'($urandom);
        v.r0 = 8'($urandom); v.r1 = 8'($urandom);
        v.k0 = $urandom_range(1, 18); v.k1 = $urandom_range(1, 18);
        if (v.do_wb && v.do_pin) f = ~m_last;
        else                     f = v.do_pin;
        s = ~f;
        res0 = (v.k0 <= TO + 1) ? v.r0 : 8'h00;
        res1 = (v.k1 <= TO + 1) ? v.r1 : 8'h00;
        wb_first = (f == 1'b0);
        v.exp_own0 = f;
        v.exp_cov0 = f ? v.pc : v.wc;
        v.exp_cov1 = s ? v.pc : v.wc;
        v.exp_wout = wb_first ? res0 : res1;
        v.exp_pout = wb_first ? res1 : res0;
        v.exp_ab   = int'(v.k0 > TO + 1) + ((v.do_wb && v.do_pin) ? int'(v.k1 > TO + 1) : 0);
        m_err      = m_err | (v.exp_ab > 0);
        v.exp_err  = m_err;
        apply_vec(v, 1'b0, $sformatf("rnd%0d", t));
        m_last = (v.do_wb && v.do_pin) ? s : f;
        if (v.do_wb) m_wb_last = v.exp_wout;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
